// File: rtl/monitor_ser_pkg.sv
// Shared types and constants for the monitor output serializer.
// Fixes the stream count and widths; the record layout derives from them.
package monitor_ser_pkg;

    localparam int NUM_OUT    = 4;
    localparam int DATA_W     = 64;
    localparam int TS_W       = 32;
    localparam int IDX_W      = $clog2(NUM_OUT);
    localparam int DROP_CNT_W = 16;

    localparam logic KIND_HEADER = 1'b0;
    localparam logic KIND_DATA   = 1'b1;

    // Header beat layout: ts in the low bits, active mask directly above it.
    localparam int HDR_TS_LSB   = 0;
    localparam int HDR_MASK_LSB = TS_W;

    typedef struct packed {
        logic [TS_W-1:0]           ts;
        logic [NUM_OUT-1:0]        mask;
        logic [NUM_OUT*DATA_W-1:0] data;
    } record_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA
    } ser_state_e;

endpackage

// File: rtl/ser_record_fifo.sv
// Single-clock record FIFO with synchronous reset to empty.
// Exposes the head and the entry behind it so the drain can chain records.
module ser_record_fifo
    import monitor_ser_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  record_t wr_rec,
    output record_t head,
    output record_t next_head,
    output logic    full,
    output logic    empty,
    output logic    multi
);

    localparam int PTR_W = $clog2(DEPTH);

    record_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic               do_push;
    logic               do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign multi     = (count > (PTR_W+1)'(1));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr + PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone decide
    // which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_rec;
    end

endmodule

// File: rtl/monitor_output_serializer.sv
// Captures monitor verdict records and drains them as header + data beats.
// Define SER_TIMESTAMP_EN to include the timestamp counter; otherwise ts reads 0.
module monitor_output_serializer
    import monitor_ser_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_kind,
    output logic [IDX_W-1:0]          m_idx,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_last,
    output logic [DROP_CNT_W-1:0]     drop_cnt,
    output logic                      overflow
);

    logic [TS_W-1:0] ts;

`ifdef SER_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (rst)     ts <= '0;
        else if (en) ts <= ts + TS_W'(1);
    end
`else
    assign ts = '0;
`endif

    logic       capture, drop, pop;
    logic       full, empty, multi;
    record_t    cap_rec, head, next_head, work;

    assign capture = en && (|out_aktv);
    assign cap_rec = '{ts: ts, mask: out_aktv, data: out_data};
    // A full FIFO only takes a capture if the drain frees a slot on the same edge.
    assign drop    = capture && full && !pop;

    ser_record_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .pop       (pop),
        .wr_rec    (cap_rec),
        .head      (head),
        .next_head (next_head),
        .full      (full),
        .empty     (empty),
        .multi     (multi)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_OUT-1:0] m);
        lowest_set = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    ser_state_e         state, state_n;
    logic [IDX_W-1:0]   cur_idx, idx_n;
    logic               load_head, load_next;
    logic [NUM_OUT-1:0] remaining;
    logic [DATA_W-1:0]  header_word;

    assign remaining = work.mask & (({NUM_OUT{1'b1}} << cur_idx) << 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_idx <= '0;
        end else begin
            state   <= state_n;
            cur_idx <= idx_n;
        end
    end

    // Working copy is only observed outside IDLE, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_head)      work <= head;
        else if (load_next) work <= next_head;
    end

    always_comb begin
        header_word = '0;
        header_word[HDR_TS_LSB +: TS_W]      = work.ts;
        header_word[HDR_MASK_LSB +: NUM_OUT] = work.mask;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_n   = state;
        idx_n     = cur_idx;
        load_head = 1'b0;
        load_next = 1'b0;
        pop       = 1'b0;
        m_valid   = 1'b0;
        m_kind    = KIND_HEADER;
        m_idx     = '0;
        m_data    = '0;
        m_last    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_n   = ST_HEADER;
                    load_head = 1'b1;
                end
            end
            ST_HEADER: begin
                m_valid = 1'b1;
                m_data  = header_word;
                if (m_ready) begin
                    state_n = ST_DATA;
                    idx_n   = lowest_set(work.mask);
                end
            end
            ST_DATA: begin
                m_valid = 1'b1;
                m_kind  = KIND_DATA;
                m_idx   = cur_idx;
                m_data  = work.data[cur_idx*DATA_W +: DATA_W];
                m_last  = (remaining == '0);
                if (m_ready) begin
                    if (!m_last) begin
                        idx_n = lowest_set(remaining);
                    end else begin
                        pop = 1'b1;
                        if (multi) begin
                            state_n   = ST_HEADER;
                            load_next = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_monitor_output_serializer.sv
// Directed bench for monitor_output_serializer; header ts expectations follow
// SER_TIMESTAMP_EN (ts field is 0 when the macro is undefined).
module tb_monitor_output_serializer;

`ifdef SER_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         en;
    logic [255:0] out_data;
    logic [3:0]   out_aktv;
    logic         m_valid;
    logic         m_ready;
    logic         m_kind;
    logic [1:0]   m_idx;
    logic [63:0]  m_data;
    logic         m_last;
    logic [15:0]  drop_cnt;
    logic         overflow;

    int vectors     = 0;
    int miscompares = 0;

    monitor_output_serializer #(.DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .out_data (out_data),
        .out_aktv (out_aktv),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_kind   (m_kind),
        .m_idx    (m_idx),
        .m_data   (m_data),
        .m_last   (m_last),
        .drop_cnt (drop_cnt),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] hdr(input logic [3:0] mask, input logic [31:0] t);
        hdr = {28'd0, mask, (TS_ON ? t : 32'd0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_stream(input int i, input logic [63:0] val);
        out_data[i*64 +: 64] = val;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        en       = 1'b0;
        out_aktv = '0;
        out_data = '0;
        m_ready  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Waits up to budget cycles for m_valid, then checks the whole beat.
    task automatic expect_beat(input string tag, input logic kind, input logic [1:0] idx,
                               input logic [63:0] data, input logic last, input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, ".valid"}, 64'(m_valid), 64'd1);
        check({tag, ".kind"},  64'(m_kind),  64'(kind));
        check({tag, ".idx"},   64'(m_idx),   64'(idx));
        check({tag, ".data"},  m_data,       data);
        check({tag, ".last"},  64'(m_last),  64'(last));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; out_aktv = '0; out_data = '0; m_ready = 1'b0;

        // Reset state
        do_reset();
        tick();
        check("rst.valid",    64'(m_valid),  64'd0);
        check("rst.kind",     64'(m_kind),   64'd0);
        check("rst.idx",      64'(m_idx),    64'd0);
        check("rst.data",     m_data,        64'd0);
        check("rst.last",     64'(m_last),   64'd0);
        check("rst.drop",     64'(drop_cnt), 64'd0);
        check("rst.overflow", 64'(overflow), 64'd0);

        // Single record, mask 0101 at ts=5
        do_reset();
        m_ready = 1'b1;
        en = 1'b1;
        repeat (5) tick();
        set_stream(0, 64'd1);
        set_stream(1, 64'd11);
        set_stream(2, 64'd100);
        set_stream(3, 64'hFFFF_FFFF_FFFF_FFFF);
        out_aktv = 4'b0101;
        tick();
        en = 1'b0; out_aktv = '0;
        check("t1.no_early", 64'(m_valid), 64'd0);
        expect_beat("t1.hdr", 1'b0, 2'd0, hdr(4'h5, 32'd5), 1'b0, 1);
        tick();
        expect_beat("t1.d0", 1'b1, 2'd0, 64'd1, 1'b0, 0);
        tick();
        expect_beat("t1.d2", 1'b1, 2'd2, 64'd100, 1'b1, 0);
        tick();
        check("t1.idle", 64'(m_valid), 64'd0);

        // Backpressure mid-record, mask 1011
        do_reset();
        m_ready = 1'b1;
        en = 1'b1;
        set_stream(0, 64'h8000_0000_0000_0001);
        set_stream(1, 64'hFFFF_FFFF_FFFF_FFFE);
        set_stream(2, 64'h0000_0000_0000_DEAD);
        set_stream(3, 64'h7FFF_FFFF_FFFF_FFFF);
        out_aktv = 4'b1011;
        tick();
        en = 1'b0; out_aktv = '0;
        expect_beat("t2.hdr", 1'b0, 2'd0, hdr(4'hB, 32'd0), 1'b0, 2);
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t2.hold.valid", 64'(m_valid), 64'd1);
            check("t2.hold.idx",   64'(m_idx),   64'd0);
            check("t2.hold.data",  m_data,       64'h8000_0000_0000_0001);
            tick();
        end
        m_ready = 1'b1;
        expect_beat("t2.d0", 1'b1, 2'd0, 64'h8000_0000_0000_0001, 1'b0, 0);
        tick();
        expect_beat("t2.d1", 1'b1, 2'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0);
        tick();
        expect_beat("t2.d3", 1'b1, 2'd3, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 0);
        tick();
        check("t2.idle", 64'(m_valid), 64'd0);

        // Overflow: 10 captures into depth 8 with the sink stalled
        do_reset();
        en = 1'b1;
        out_aktv = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            set_stream(0, 64'(i));
            tick();
        end
        en = 1'b0; out_aktv = '0;
        check("t3.drop",     64'(drop_cnt), 64'd2);
        check("t3.overflow", 64'(overflow), 64'd1);
        m_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            expect_beat("t3.hdr", 1'b0, 2'd0, hdr(4'h1, 32'(r)), 1'b0, 0);
            tick();
            expect_beat("t3.dat", 1'b1, 2'd0, 64'(r), 1'b1, 0);
            tick();
        end
        check("t3.idle",        64'(m_valid),  64'd0);
        check("t3.sticky",      64'(overflow), 64'd1);
        check("t3.drop_after",  64'(drop_cnt), 64'd2);

        // Full FIFO with a capture on the same edge as the final-beat pop
        do_reset();
        en = 1'b1;
        out_aktv = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            set_stream(0, 64'(100 + i));
            tick();
        end
        en = 1'b0; out_aktv = '0;
        check("t4.full_nodrop", 64'(drop_cnt), 64'd0);
        m_ready = 1'b1;
        tick();
        expect_beat("t4.d_rec0", 1'b1, 2'd0, 64'd100, 1'b1, 0);
        en = 1'b1; out_aktv = 4'b0001;
        set_stream(0, 64'd200);
        tick();
        en = 1'b0; out_aktv = '0;
        check("t4.drop",     64'(drop_cnt), 64'd0);
        check("t4.overflow", 64'(overflow), 64'd0);
        for (int r = 1; r < 8; r++) begin
            expect_beat("t4.hdr", 1'b0, 2'd0, hdr(4'h1, 32'(r)), 1'b0, 0);
            tick();
            expect_beat("t4.dat", 1'b1, 2'd0, 64'(100 + r), 1'b1, 0);
            tick();
        end
        expect_beat("t4.hdr_new", 1'b0, 2'd0, hdr(4'h1, 32'd8), 1'b0, 0);
        tick();
        expect_beat("t4.dat_new", 1'b1, 2'd0, 64'd200, 1'b1, 0);
        tick();
        check("t4.idle", 64'(m_valid), 64'd0);

        // Back-to-back records, mask 1000: no idle cycle between records
        do_reset();
        en = 1'b1;
        out_aktv = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            set_stream(3, 64'(48 + i));
            tick();
        end
        en = 1'b0; out_aktv = '0;
        m_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            expect_beat("t5.hdr", 1'b0, 2'd0, hdr(4'h8, 32'(r)), 1'b0, 0);
            tick();
            expect_beat("t5.dat", 1'b1, 2'd3, 64'(48 + r), 1'b1, 0);
            tick();
        end
        check("t5.idle", 64'(m_valid), 64'd0);

        // Reset during a data beat, with drops and buffered records pending
        do_reset();
        en = 1'b1;
        out_aktv = 4'b0011;
        set_stream(0, 64'd7);
        set_stream(1, 64'd8);
        repeat (10) tick();
        en = 1'b0; out_aktv = '0;
        check("t6.pre_drop", 64'(drop_cnt), 64'd2);
        m_ready = 1'b1;
        expect_beat("t6.hdr", 1'b0, 2'd0, hdr(4'h3, 32'd0), 1'b0, 0);
        tick();
        expect_beat("t6.d0", 1'b1, 2'd0, 64'd7, 1'b0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6.valid",    64'(m_valid),  64'd0);
        check("t6.drop",     64'(drop_cnt), 64'd0);
        check("t6.overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6.discarded", 64'(m_valid), 64'd0);
        end
        en = 1'b1; out_aktv = 4'b0001;
        set_stream(0, 64'd77);
        tick();
        en = 1'b0; out_aktv = '0;
        expect_beat("t6.fresh_hdr", 1'b0, 2'd0, hdr(4'h1, 32'd0), 1'b0, 2);
        tick();
        expect_beat("t6.fresh_d0", 1'b1, 2'd0, 64'd77, 1'b1, 0);
        tick();
        check("t6.idle", 64'(m_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
